// File: rtl/greyscale_frame_ctrl.sv
// greyscale_frame_ctrl
// Walks the 12-bit RGB image BRAM once in raster order and writes an 8-bit
// luma value for every pixel into the greyscale output BRAM.
//
// Handshake:
//   - start is sampled in IDLE only.
//   - busy covers the first issue cycle through the final write.
//   - done is a one-cycle pulse that follows the final write.
//
// Read/write alignment:
//   - Each issued read pushes its address into a valid/address shift pipe.
//   - The pipe is RD_LATENCY stages long, so its tail lines up with rd_data.
//   - The registered output stage is the final (+1) stage.
//   - The write therefore lands RD_LATENCY+1 cycles after the read.
//
// Hold:
//   - hold only gates new issues.
//   - Reads already in the pipe still retire and are written.
//
// RD_LATENCY is legal in the range 1..4.
// ADDR_W is derived from the frame size and must not be overridden.

module greyscale_frame_ctrl #(
    parameter int WIDTH      = 128,
    parameter int HEIGHT     = 128,
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk_100mhz,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              hold,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);

    localparam int                N_PIXELS  = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Luma approximation: s = 5r + 9g + 2b, then s + s/16.
    // All products are shift-add, so no multiplier is needed.
    // s tops out at 240, so 8 bits never overflow.
    // The final scaling tops out at 240 + 15 = 255.
    function automatic logic [7:0] luma_f(input logic [11:0] px);
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic [7:0] r5;
        logic [7:0] g9;
        logic [7:0] b2;
        logic [7:0] s;
        r  = px[11:8];
        g  = px[7:4];
        b  = px[3:0];
        r5 = {2'b00, r, 2'b00} + {4'b0000, r};
        g9 = {1'b0, g, 3'b000} + {4'b0000, g};
        b2 = {3'b000, b, 1'b0};
        s  = r5 + g9 + b2;
        return s + {4'b0000, s[7:4]};
    endfunction

    state_t            state_r;
    logic [RD_LATENCY-1:0] vld_pipe_r;
    logic [ADDR_W-1:0] addr_pipe_r [RD_LATENCY];
    logic              issue_s;
    logic              pipe_empty_s;
    logic              pipe_tail_vld_s;
    logic [ADDR_W-1:0] pipe_tail_addr_s;

    // Decide whether a read is issued this cycle and summarise the pipe state.
    always_comb begin
        issue_s          = 1'b0;
        pipe_empty_s     = 1'b0;
        pipe_tail_vld_s  = vld_pipe_r[RD_LATENCY-1];
        pipe_tail_addr_s = addr_pipe_r[RD_LATENCY-1];
        if ((state_r == RUN) && !hold) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        if (vld_pipe_r == '0) begin
            pipe_empty_s = 1'b1;
        end else begin
            pipe_empty_s = 1'b0;
        end
    end

    // Valid/address shift pipe that tracks reads while they are in flight in the BRAM.
    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            vld_pipe_r <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                addr_pipe_r[i] <= '0;
            end
        end else begin
            vld_pipe_r[0]  <= issue_s;
            addr_pipe_r[0] <= rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                addr_pipe_r[i] <= addr_pipe_r[i-1];
            end
        end
    end

    // Registered write stage: converts the returning pixel and drives the output BRAM.
    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'd0;
        end else begin
            wr_en <= pipe_tail_vld_s;
            if (pipe_tail_vld_s) begin
                wr_addr <= pipe_tail_addr_s;
                wr_data <= luma_f(rd_data);
            end else begin
                wr_addr <= wr_addr;
                wr_data <= wr_data;
            end
        end
    end

    // Frame sequencer.
    // rd_addr doubles as the issue counter, so rd_addr is the address being presented.
    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            state_r <= IDLE;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done    <= 1'b0;
                    rd_addr <= '0;
                    if (start) begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        if (rd_addr == LAST_ADDR) begin
                            // Last pixel issued; keep the address, no wrap.
                            state_r <= DRAIN;
                        end else begin
                            rd_addr <= rd_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        rd_addr <= rd_addr;
                    end
                end
                DRAIN: begin
                    // An empty pipe here means the final write is on wr_en this cycle.
                    if (pipe_empty_s) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rd_addr <= '0;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    rd_addr <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_greyscale_frame_ctrl.sv
// Self-checking bench for greyscale_frame_ctrl.
// Uses a 4x4 frame with RD_LATENCY=2 and a latency-2 BRAM model.
// Expected writes are queued when a frame starts and popped as wr_en fires.

module tb_greyscale_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int RL = 2;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);

    logic          clk_100mhz = 1'b0;
    logic          sys_rst    = 1'b1;
    logic          start      = 1'b0;
    logic          hold       = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [11:0]   rd_data;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          busy;
    logic          done;

    greyscale_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .RD_LATENCY(RL)) dut (
        .clk_100mhz (clk_100mhz),
        .sys_rst    (sys_rst),
        .start      (start),
        .hold       (hold),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Cycle index: "cycle k" is the period after the posedge that set cyc to k.
    int cyc = 0;
    always @(posedge clk_100mhz) cyc <= cyc + 1;

    // Image BRAM model with two-cycle read latency.
    logic [11:0] mem [N];
    logic [11:0] rd_q1;
    always @(posedge clk_100mhz) begin
        rd_q1   <= mem[rd_addr];
        rd_data <= rd_q1;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } exp_t;
    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;
    int wr_count, first_wr, last_wr, hold_wr, done_cnt;
    logic [7:0] wr_log [N];
    int s_cyc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_luma(input logic [11:0] px);
        int s;
        s = 5 * int'(px[11:8]) + 9 * int'(px[7:4]) + 2 * int'(px[3:0]);
        return 8'(s + s / 16);
    endfunction

    // Output monitor: scoreboard compare on each write, plus done bookkeeping.
    always @(negedge clk_100mhz) begin
        exp_t e;
        if (wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("extra_wr", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("wr_addr", 32'(wr_addr), 32'(e.addr));
                check_val("wr_data", 32'(wr_data), 32'(e.data));
            end
            check_val("busy_on_wr", 32'(busy), 32'd1);
            wr_log[wr_addr] = wr_data;
            if (wr_count == 0) first_wr = cyc;
            last_wr = cyc;
            wr_count++;
            if (hold === 1'b1) hold_wr++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            check_val("busy_done_excl", 32'(busy), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic start_frame();
        exp_t e;
        step();
        start    = 1'b1;
        s_cyc    = cyc;
        wr_count = 0;
        hold_wr  = 0;
        done_cnt = 0;
        first_wr = -1;
        last_wr  = -1;
        for (int i = 0; i < N; i++) begin
            e.addr = AW'(i);
            e.data = ref_luma(mem[i]);
            sb_q.push_back(e);
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int got;
        got  = 0;
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_100mhz);
            if (done === 1'b1) begin
                got  = 1;
                dcyc = cyc;
                break;
            end
        end
        if (got == 0) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string tag, input int dcyc, input int extra);
        check_val({tag, "_done_cyc"}, 32'(dcyc - s_cyc), 32'(N + RL + 2 + extra));
        check_val({tag, "_first_wr"}, 32'(first_wr - s_cyc), 32'(RL + 2));
        check_val({tag, "_last_wr"}, 32'(last_wr - s_cyc), 32'(N + RL + 1 + extra));
        check_val({tag, "_wr_count"}, 32'(wr_count), 32'(N));
        check_val({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int d;
        for (int i = 0; i < N; i++) mem[i] = 12'(i * 12'h111);

        // Reset, then 20 idle cycles with everything quiet.
        repeat (3) step();
        sys_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_100mhz);
            check_val("idle_outputs", {16'd0, 4'(rd_addr), 4'(wr_addr), wr_data} | 32'({wr_en, busy, done}), 32'd0);
        end

        // Plain frame, no hold.
        start_frame();
        wait_done(100, d);
        check_frame("f1", d, 0);
        check_val("f1_px0", 32'(wr_log[0]), 32'd0);
        check_val("f1_px111", 32'(wr_log[1]), 32'd17);
        check_val("f1_pxfff", 32'(wr_log[15]), 32'd255);
        step();
        check_val("f1_rd_addr_idle", 32'(rd_addr), 32'd0);

        // Hold high for cycles s+3..s+7; in-flight reads still write.
        start_frame();
        while (cyc < s_cyc + 3) step();
        hold = 1'b1;
        while (cyc < s_cyc + 8) step();
        hold = 1'b0;
        wait_done(100, d);
        check_frame("hold", d, 5);
        check_val("hold_inflight_wr", 32'(hold_wr), 32'd2);

        // Primary-colour pixels; a second start while busy is ignored.
        mem[0] = 12'hF00;
        mem[1] = 12'h0F0;
        mem[2] = 12'h00F;
        start_frame();
        while (cyc < s_cyc + 5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(100, d);
        check_frame("pix", d, 0);
        check_val("pix_red", 32'(wr_log[0]), 32'd79);
        check_val("pix_green", 32'(wr_log[1]), 32'd143);
        check_val("pix_blue", 32'(wr_log[2]), 32'd31);
        repeat (30) @(negedge clk_100mhz);
        check_val("pix_no_refire", 32'(done_cnt), 32'd1);

        // Reset at s+10 aborts the frame.
        start_frame();
        while (cyc < s_cyc + 10) step();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        sb_q.delete();
        @(negedge clk_100mhz);
        check_val("abort_wr_en", 32'(wr_en), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_rd_addr", 32'(rd_addr), 32'd0);
        check_val("abort_wr_count", 32'(wr_count), 32'd7);
        repeat (30) @(negedge clk_100mhz);
        check_val("abort_no_done", 32'(done_cnt), 32'd0);

        // Clean frame after the abort, then back-to-back start the cycle after done.
        start_frame();
        wait_done(100, d);
        check_frame("post_rst", d, 0);
        start_frame();
        check_val("b2b_start_cyc", 32'(s_cyc - d), 32'd1);
        wait_done(100, d);
        check_frame("b2b", d, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
